// File: rtl/bitslip_align_if.sv
// Bitslip alignment controller bus: training request, aligned word in, bit position
// and status out. master = sequencer/bitslip side, slave = controller.
interface bitslip_align_if #(
  parameter int DATA_BITS = 8,
  parameter int CNT_BITS  = 3
);
  logic                 start;
  logic [DATA_BITS-1:0] din;
  logic [CNT_BITS-1:0]  bitpos;
  logic                 busy;
  logic                 locked;
  logic                 fail;
  logic                 lock_lost;

  modport master (output start, din, input bitpos, busy, locked, fail, lock_lost);
  modport slave  (input start, din, output bitpos, busy, locked, fail, lock_lost);
endinterface

// File: rtl/bitslip_align_ctrl.sv
// Word-alignment training controller: sweeps bitpos, locks on MATCH_CNT consecutive
// training words, watches for loss of lock. ALIGN_RELOCK_EN enables automatic retrain.
module bitslip_align_ctrl #(
  parameter int                   DATA_BITS     = 8,
  parameter int                   CNT_BITS      = 3,
  parameter logic [DATA_BITS-1:0] TRAIN_PATTERN = 8'h5C,
  parameter int                   SETTLE_CYC    = 4,
  parameter int                   MATCH_CNT     = 16,
  parameter int                   LOSS_CNT      = 4,
  parameter int                   MAX_PASSES    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  bitslip_align_if.slave bus
);
  localparam int CW = $clog2(SETTLE_CYC + MATCH_CNT + LOSS_CNT + 1);
  localparam int PW = $clog2(MAX_PASSES + 1);

  typedef enum logic [2:0] {IDLE, SETTLE, CHECK, NEXT, LOCKED, FAILED} state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [PW-1:0]       pass, pass_n;
  logic [CNT_BITS-1:0] bitpos_q, bitpos_n;
  logic                lost_n;
  logic                busy_q, locked_q, fail_q, lost_q;
  logic                match;

  assign match = (bus.din == TRAIN_PATTERN);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    pass_n   = pass;
    bitpos_n = bitpos_q;
    lost_n   = 1'b0;
    case (state)
      IDLE, FAILED: begin
        if (bus.start) begin
          state_n  = SETTLE;
          cnt_n    = '0;
          pass_n   = '0;
          bitpos_n = '0;
        end
      end
      SETTLE: begin
        if (cnt == CW'(SETTLE_CYC - 1)) begin
          state_n = CHECK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      CHECK: begin
        if (!match) begin
          state_n = NEXT;
          cnt_n   = '0;
        end else if (cnt == CW'(MATCH_CNT - 1)) begin
          state_n = LOCKED;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      NEXT: begin
        state_n = SETTLE;
        cnt_n   = '0;
        if (bitpos_q == CNT_BITS'(DATA_BITS - 1)) begin
          bitpos_n = '0;
          pass_n   = pass + PW'(1);
          if (pass + PW'(1) == PW'(MAX_PASSES)) state_n = FAILED;
        end else begin
          bitpos_n = bitpos_q + CNT_BITS'(1);
        end
      end
      LOCKED: begin
        // start outranks a coincident loss of lock: retrain, no lock_lost pulse
        if (bus.start) begin
          state_n  = SETTLE;
          cnt_n    = '0;
          pass_n   = '0;
          bitpos_n = '0;
        end else if (match) begin
          cnt_n = '0;
        end else if (cnt == CW'(LOSS_CNT - 1)) begin
          lost_n = 1'b1;
          cnt_n  = '0;
`ifdef ALIGN_RELOCK_EN
          state_n = SETTLE;
          pass_n  = '0;
`else
          state_n = IDLE;
`endif
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Status flags are decoded from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      pass     <= '0;
      bitpos_q <= '0;
      busy_q   <= 1'b0;
      locked_q <= 1'b0;
      fail_q   <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pass     <= pass_n;
      bitpos_q <= bitpos_n;
      busy_q   <= (state_n == SETTLE) || (state_n == CHECK) || (state_n == NEXT);
      locked_q <= (state_n == LOCKED);
      fail_q   <= (state_n == FAILED);
      lost_q   <= lost_n;
    end
  end

  assign bus.bitpos    = bitpos_q;
  assign bus.busy      = busy_q;
  assign bus.locked    = locked_q;
  assign bus.fail      = fail_q;
  assign bus.lock_lost = lost_q;
endmodule

// File: tb/tb_bitslip_align_ctrl.sv
// Scoreboard bench for bitslip_align_ctrl: a bitslip model feeds din, expected status
// events are queued by the stimulus and checked by an independent monitor.
module tb_bitslip_align_ctrl;
  localparam logic [7:0] PAT = 8'h5C;
  localparam int K_LOCK = 0, K_FAIL = 1, K_LOST = 2;
  localparam int M_MODEL = 0, M_RAND = 1, M_BAD = 2;
`ifdef ALIGN_RELOCK_EN
  localparam bit RELOCK = 1'b1;
`else
  localparam bit RELOCK = 1'b0;
`endif

  typedef struct {
    int       kind;
    logic [2:0] bp;
    logic     busy;
    logic     locked;
    logic     fail;
    int       cyc;
  } ev_t;

  logic clk, rst_n;
  int   cyc, start_cyc, checks, errors, mode;
  logic [2:0] off;
  logic lk_p, fl_p;
  ev_t  sb[$];

  bitslip_align_if #(.DATA_BITS(8), .CNT_BITS(3)) bus();

  bitslip_align_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  function automatic logic [7:0] model(input logic [2:0] bp, input logic [2:0] o);
    logic [2:0] r;
    logic [7:0] p;
    r = bp - o;
    p = PAT;
    return (p << r) | (p >> (4'd8 - {1'b0, r}));
  endfunction

  // Bitslip stage: one cycle of latency after bitpos changes.
  initial begin
    logic [7:0] w;
    forever begin
      @(posedge clk);
      #2;
      case (mode)
        M_MODEL: bus.din = model(bus.bitpos, off);
        M_RAND: begin
          w = 8'($urandom);
          if (w == PAT) w = 8'hA3;
          bus.din = w;
        end
        default: bus.din = 8'h00;
      endcase
    end
  end

  // Monitor: every rise of locked/fail and every lock_lost cycle must match the queue head.
  initial begin
    ev_t e;
    int  k;
    lk_p = 1'b0;
    fl_p = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && ((bus.locked && !lk_p) || (bus.fail && !fl_p) || bus.lock_lost)) begin
        k = bus.lock_lost ? K_LOST : (bus.fail ? K_FAIL : K_LOCK);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got kind=%0d bitpos=%0d at cycle %0d, required no event",
                   k, bus.bitpos, cyc - start_cyc);
        end else begin
          e = sb.pop_front();
          if (k != e.kind || bus.bitpos != e.bp || bus.busy != e.busy || bus.locked != e.locked ||
              bus.fail != e.fail || (e.cyc >= 0 && (cyc - start_cyc) != e.cyc)) begin
            errors++;
            $display("FAIL event: got kind=%0d bitpos=%0d busy=%0d locked=%0d fail=%0d cyc=%0d, required kind=%0d bitpos=%0d busy=%0d locked=%0d fail=%0d cyc=%0d",
                     k, bus.bitpos, bus.busy, bus.locked, bus.fail, cyc - start_cyc,
                     e.kind, e.bp, e.busy, e.locked, e.fail, e.cyc);
          end
        end
      end
      lk_p = bus.locked;
      fl_p = bus.fail;
    end
  end

  task automatic push(input int kind, input logic [2:0] bp, input logic busy,
                      input logic locked, input logic fail, input int c);
    ev_t e;
    e.kind = kind; e.bp = bp; e.busy = busy; e.locked = locked; e.fail = fail; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic drain(input int max, input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending events after %0d cycles, required 0", nm, sb.size(), max);
      sb.delete();
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    start_cyc = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic bad_good(input int nbad, input int ngood);
    mode = M_BAD;
    repeat (nbad) @(negedge clk);
    mode = M_MODEL;
    repeat (ngood) @(negedge clk);
  endtask

  initial begin
    int n;
    checks = 0; errors = 0; start_cyc = 0;
    mode = M_MODEL; off = 3'd5;
    rst_n = 1'b0; bus.start = 1'b0; bus.din = 8'h00;

    // 1: reset values
    repeat (3) @(negedge clk);
    chk("rst_bitpos", 32'(bus.bitpos), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_locked", 32'(bus.locked), 0);
    chk("rst_fail", 32'(bus.fail), 0);
    chk("rst_lock_lost", 32'(bus.lock_lost), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 2: true offset 5 locks after 5*6 + 4 + 16 = 50 cycles
    push(K_LOCK, 3'd5, 1'b0, 1'b1, 1'b0, 50);
    pulse_start();
    chk("t2_busy_after_start", 32'(bus.busy), 1);
    drain(200, "t2_lock");
    repeat (10) @(negedge clk);
    chk("t2_bitpos_stable", 32'(bus.bitpos), 5);
    chk("t2_locked_held", 32'(bus.locked), 1);

    // 3: random data -> fail after 2 passes of 8 positions (16*6 = 96 cycles)
    mode = M_RAND;
    push(K_FAIL, 3'd0, 1'b0, 1'b0, 1'b1, 96);
    pulse_start();
    drain(300, "t3_fail");
    repeat (5) @(negedge clk);
    chk("t3_fail_sticky", 32'(bus.fail), 1);
    mode = M_MODEL; off = 3'd3;
    push(K_LOCK, 3'd3, 1'b0, 1'b1, 1'b0, 38);
    pulse_start();
    chk("t3_fail_cleared", 32'(bus.fail), 0);
    chk("t3_busy_restart", 32'(bus.busy), 1);
    drain(200, "t3_lock3");

    // 4: four bad words while locked at 3
    push(K_LOST, 3'd3, RELOCK, 1'b0, 1'b0, -1);
    if (RELOCK) push(K_LOCK, 3'd3, 1'b0, 1'b1, 1'b0, -1);
    bad_good(4, 1);
    drain(200, "t4_loss");
    chk("t4_bitpos", 32'(bus.bitpos), 3);
    chk("t4_locked", 32'(bus.locked), RELOCK ? 1 : 0);
    chk("t4_busy", 32'(bus.busy), 0);

    // 5: start (retrain from 0, locked drops, no lock_lost), then 3 bad + 1 good repeated
    push(K_LOCK, 3'd3, 1'b0, 1'b1, 1'b0, 38);
    pulse_start();
    chk("t5_locked_drop", 32'(bus.locked), 0);
    chk("t5_busy", 32'(bus.busy), 1);
    chk("t5_bitpos_zero", 32'(bus.bitpos), 0);
    chk("t5_no_lost", 32'(bus.lock_lost), 0);
    drain(200, "t5_lock");
    for (int i = 0; i < 4; i++) bad_good(3, 1);
    repeat (3) @(negedge clk);
    chk("t5_still_locked", 32'(bus.locked), 1);

    // 6: reset during CHECK at bitpos 4, then restart sweep from 0
    off = 3'd6;
    pulse_start();
    n = 0;
    while (bus.bitpos != 3'd4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reach_bitpos4", 32'(bus.bitpos), 4);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_bitpos", 32'(bus.bitpos), 0);
    chk("t6_rst_busy", 32'(bus.busy), 0);
    chk("t6_rst_locked", 32'(bus.locked), 0);
    chk("t6_rst_fail", 32'(bus.fail), 0);
    chk("t6_rst_lock_lost", 32'(bus.lock_lost), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push(K_LOCK, 3'd6, 1'b0, 1'b1, 1'b0, 56);
    pulse_start();
    drain(200, "t6_relock");

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
